pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32: payload width; payload is not cleared on flush.
REQ-002 Parameter CTRL_W, default 16: control-signal bundle width; cleared on flush and reset.
REQ-003 Parameter CNT_W, default 32: statistics counter width.
REQ-004 clock  in  1  sole clock; all state updates on posedge clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  upstream stage presents a beat.
REQ-007 in_ready  out  1  stage accepts a beat this cycle.
REQ-008 in_data  in  DATA_W  upstream payload (PC, operands, ALU result).
REQ-009 in_ctrl  in  CTRL_W  upstream control bundle (writeEnable, memRead, memWrite, mux selects).
REQ-010 out_valid  out  1  beat presented downstream.
REQ-011 out_ready  in  1  downstream accepts the beat.
REQ-012 out_data  out  DATA_W  payload of the head entry.
REQ-013 out_ctrl  out  CTRL_W  control bundle of the head entry.
REQ-014 hold  in  1  global freeze (memory busywait).
REQ-015 flush  in  1  bubble insertion (branch mispredict, load-use).
REQ-016 occupancy  out  2  entries held: 0, 1 or 2.
REQ-017 stall_cnt  out  CNT_W  saturating stall-cycle count.
REQ-018 flush_cnt  out  CNT_W  saturating flush-cycle count.

Function
REQ-019 The stage SHALL hold two entries: a head register and a skid register, each with a valid bit, payload and ctrl.
REQ-020 States SHALL be EMPTY (occ 0), ONE (head valid), FULL (head and skid valid).
REQ-021 in_ready SHALL equal !skid_valid && !hold && !flush, driven from registered state only, with no combinational path from out_ready.
REQ-022 out_valid SHALL equal head_valid && !hold; out_data/out_ctrl SHALL always show the head entry.
REQ-023 Accept = in_valid && in_ready; release = out_valid && out_ready.
REQ-024 EMPTY: accept -> ONE, beat loaded into head; latency from accept to out_valid is exactly 1 cycle.
REQ-025 ONE: accept and release -> ONE, head replaced by new beat; accept only -> FULL, beat loaded into skid; release only -> EMPTY.
REQ-026 FULL: release -> ONE, skid moves to head in the same edge; otherwise stays FULL.
REQ-027 Beat order SHALL be strictly preserved; no beat is duplicated or dropped except by flush.
REQ-028 hold=1 SHALL freeze all entry state; no accept and no release occur.
REQ-029 flush=1 SHALL on the next edge clear both valid bits and both ctrl registers to zero, retain payloads, and go to EMPTY.
REQ-030 Priority SHALL be reset > flush > hold > normal; a beat offered in a flush cycle is discarded.
REQ-031 When head_valid=0, out_ctrl SHALL read all zero, so a bubble carries no write or memory enables.

Reset
REQ-032 On reset: valids=0, ctrl=0, occupancy=0, counters=0; payload registers are cleared to 0.
REQ-033 Reset asserted mid-transfer SHALL discard all held beats; in_ready=0 and out_valid=0 while reset is high.

Configuration
REQ-034 With PIPE_STAGE_STATS_EN defined, stall_cnt SHALL increment each cycle with head_valid && (hold || !out_ready), and flush_cnt SHALL increment each flush cycle; both saturate at all-ones.
REQ-035 Without PIPE_STAGE_STATS_EN, stall_cnt and flush_cnt SHALL remain present and tied to zero, with no counter flops.

Structure
REQ-036 Package pipe_pkg SHALL hold the occupancy state enum (OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2) and the default DATA_W/CTRL_W/CNT_W constants.
REQ-037 Saturating counters SHALL use one sub-module, pipe_sat_counter (parameter W; ports clock, reset, inc, count), instantiated twice under the macro.

Verification
REQ-038 Reset, then in_data=0x100 and in_ctrl=0x0005 with out_ready=1 -> out_valid next cycle with 0x100/0x0005 and occupancy=1.
REQ-039 out_ready=0 with beats 0xA then 0xB -> occupancy=2, in_ready=0; raise out_ready -> 0xA then 0xB on consecutive cycles.
REQ-040 FULL with flush=1 and in_valid=1 (0xC) -> next cycle occupancy=0, out_ctrl=0, and 0xC never appears.
REQ-041 hold=1 for 3 cycles while ONE -> out_valid=0, state unchanged; release after hold -> same beat emitted once.
REQ-042 With PIPE_STAGE_STATS_EN and CNT_W=4, stall 20 cycles -> stall_cnt=15 (saturated); without the macro -> 0.
REQ-043 Reset and flush asserted together in FULL -> all outputs at reset values and flush_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and occupancy state for the pipeline stage register
package pipe_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_CTRL_W = 16;
  localparam int PIPE_CNT_W  = 32;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - counter that increments on inc and sticks at all-ones
module pipe_sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - two-entry (head + skid) pipeline stage with hold/flush
// Define PIPE_STAGE_STATS_EN to enable the saturating stall/flush counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              hold,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  occ_state_e        state_q;
  logic [DATA_W-1:0] head_data_q, skid_data_q;
  logic [CTRL_W-1:0] head_ctrl_q, skid_ctrl_q;
  logic              head_valid, skid_valid;
  logic              accept, release_beat;

  assign head_valid   = (state_q != OCC_EMPTY);
  assign skid_valid   = (state_q == OCC_FULL);
  assign in_ready     = !reset && !skid_valid && !hold && !flush;
  assign out_valid    = !reset && head_valid && !hold;
  assign accept       = in_valid && in_ready;
  assign release_beat = out_valid && out_ready;

  assign out_data  = head_data_q;
  assign out_ctrl  = head_valid ? head_ctrl_q : '0;
  assign occupancy = state_q;

  // hold needs no branch of its own: it already forces accept and release low
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= OCC_EMPTY;
      head_data_q <= '0;
      head_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else if (flush) begin
      state_q     <= OCC_EMPTY;
      head_ctrl_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      unique case (state_q)
        OCC_EMPTY: begin
          if (accept) begin
            head_data_q <= in_data;
            head_ctrl_q <= in_ctrl;
            state_q     <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (accept && release_beat) begin
            head_data_q <= in_data;
            head_ctrl_q <= in_ctrl;
          end else if (accept) begin
            skid_data_q <= in_data;
            skid_ctrl_q <= in_ctrl;
            state_q     <= OCC_FULL;
          end else if (release_beat) begin
            head_ctrl_q <= '0;
            state_q     <= OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (release_beat) begin
            head_data_q <= skid_data_q;
            head_ctrl_q <= skid_ctrl_q;
            skid_ctrl_q <= '0;
            state_q     <= OCC_ONE;
          end
        end
        default: state_q <= OCC_EMPTY;
      endcase
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (head_valid && (hold || !out_ready)),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (flush),
    .count (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - randomized and directed bench for pipe_stage_reg against a queue model
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int NW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          hold = 1'b0;
  logic          flush = 1'b0;
  logic [1:0]    occupancy;
  logic [NW-1:0] stall_cnt;
  logic [NW-1:0] flush_cnt;

  int total = 0;
  int bad = 0;

  logic [DW+CW-1:0] mq[$];
  int m_stall = 0;
  int m_flush = 0;

  always #5 clock = ~clock;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .hold      (hold),
    .flush     (flush),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  function automatic bit m_in_ready();
    return !reset && (mq.size() < 2) && !hold && !flush;
  endfunction

  function automatic bit m_out_valid();
    return !reset && (mq.size() > 0) && !hold;
  endfunction

  function automatic logic [NW-1:0] exp_stall();
`ifdef PIPE_STAGE_STATS_EN
    return NW'(m_stall);
`else
    return '0;
`endif
  endfunction

  function automatic logic [NW-1:0] exp_flush();
`ifdef PIPE_STAGE_STATS_EN
    return NW'(m_flush);
`else
    return '0;
`endif
  endfunction

  // advance one clock, updating the queue model from the inputs seen before the edge
  task automatic tick();
    bit acc, rel, st, fl, rs;
    logic [DW+CW-1:0] nd;
    acc = in_valid && m_in_ready();
    rel = m_out_valid() && out_ready;
    st  = (mq.size() > 0) && (hold || !out_ready);
    fl  = flush;
    rs  = reset;
    nd  = {in_data, in_ctrl};
    @(posedge clock);
    if (rs) begin
      mq.delete();
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (st && m_stall < (1 << NW) - 1) m_stall++;
      if (fl && m_flush < (1 << NW) - 1) m_flush++;
      if (fl) mq.delete();
      else begin
        if (rel) void'(mq.pop_front());
        if (acc) mq.push_back(nd);
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; hold = 0; flush = 0; reset = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [CW-1:0] c);
    in_valid = 1; in_data = d; in_ctrl = c;
    tick();
    in_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got %0b want 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
    reset = 0;
    #1;
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL rst_occ got %0d want 0", occupancy); end
    total++; if (out_ctrl !== '0) begin bad++; $display("FAIL rst_ctrl got %0h want 0", out_ctrl); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL rst_data got %0h want 0", out_data); end
    total++; if (stall_cnt !== '0 || flush_cnt !== '0) begin bad++; $display("FAIL rst_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1;
    push(32'h100, 16'h0005);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got %0b want 1", out_valid); end
    total++; if (out_data !== 32'h100) begin bad++; $display("FAIL single_data got %0h want 100", out_data); end
    total++; if (out_ctrl !== 16'h0005) begin bad++; $display("FAIL single_ctrl got %0h want 5", out_ctrl); end
    total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL single_occ got %0d want 1", occupancy); end
    tick();
    total++; if (occupancy !== 2'd0 || out_ctrl !== '0) begin bad++; $display("FAIL single_drain got occ=%0d ctrl=%0h want 0/0", occupancy, out_ctrl); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 0;
    push(32'hA, 16'h1);
    push(32'hB, 16'h2);
    total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL b2b_occ got %0d want 2", occupancy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready got %0b want 0", in_ready); end
    out_ready = 1;
    #1;
    total++; if (out_valid !== 1'b1 || out_data !== 32'hA) begin bad++; $display("FAIL b2b_first got v=%0b d=%0h want 1/a", out_valid, out_data); end
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 32'hB || out_ctrl !== 16'h2) begin bad++; $display("FAIL b2b_second got v=%0b d=%0h c=%0h want 1/b/2", out_valid, out_data, out_ctrl); end
    tick();
    total++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin bad++; $display("FAIL b2b_empty got v=%0b occ=%0d want 0/0", out_valid, occupancy); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 0;
    push(32'hA, 16'h7);
    push(32'hB, 16'h9);
    flush = 1; in_valid = 1; in_data = 32'hC; in_ctrl = 16'hF;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got %0b want 0", in_ready); end
    tick();
    flush = 0; in_valid = 0; out_ready = 1;
    #1;
    total++; if (occupancy !== 2'd0 || out_ctrl !== '0) begin bad++; $display("FAIL flush_clear got occ=%0d ctrl=%0h want 0/0", occupancy, out_ctrl); end
    for (int i = 0; i < 3; i++) begin
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_leak got valid=%0b data=%0h want 0", out_valid, out_data); end
      tick();
    end
  endtask

  task automatic test_hold();
    do_reset();
    out_ready = 0;
    push(32'hD, 16'h3);
    hold = 1; out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (out_valid !== 1'b0 || occupancy !== 2'd1 || in_ready !== 1'b0) begin bad++; $display("FAIL hold_freeze got v=%0b occ=%0d rdy=%0b want 0/1/0", out_valid, occupancy, in_ready); end
      tick();
    end
    hold = 0;
    #1;
    total++; if (out_valid !== 1'b1 || out_data !== 32'hD || out_ctrl !== 16'h3) begin bad++; $display("FAIL hold_release got v=%0b d=%0h c=%0h want 1/d/3", out_valid, out_data, out_ctrl); end
    tick();
    total++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin bad++; $display("FAIL hold_once got v=%0b occ=%0d want 0/0", out_valid, occupancy); end
  endtask

  task automatic test_stall_sat();
    logic [NW-1:0] want;
    do_reset();
    out_ready = 0;
    push(32'h55, 16'h1);
    for (int i = 0; i < 20; i++) tick();
`ifdef PIPE_STAGE_STATS_EN
    want = 4'd15;
`else
    want = 4'd0;
`endif
    total++; if (stall_cnt !== want) begin bad++; $display("FAIL stall_sat got %0d want %0d", stall_cnt, want); end
  endtask

  task automatic test_reset_flush();
    do_reset();
    out_ready = 0;
    push(32'h11, 16'h4);
    push(32'h22, 16'h8);
    reset = 1; flush = 1;
    tick();
    reset = 0; flush = 0;
    #1;
    total++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0) begin bad++; $display("FAIL rstflush_state got occ=%0d v=%0b c=%0h d=%0h want 0/0/0/0", occupancy, out_valid, out_ctrl, out_data); end
    total++; if (flush_cnt !== '0 || stall_cnt !== '0) begin bad++; $display("FAIL rstflush_cnt got %0d/%0d want 0/0", flush_cnt, stall_cnt); end
  endtask

  task automatic test_random();
    logic [CW-1:0] want_ctrl;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      in_data   = $urandom;
      in_ctrl   = CW'($urandom);
      out_ready = ($urandom_range(0, 99) < 55);
      hold      = ($urandom_range(0, 99) < 10);
      flush     = ($urandom_range(0, 99) < 5);
      reset     = ($urandom_range(0, 99) < 2);
      #1;
      want_ctrl = (mq.size() > 0) ? mq[0][CW-1:0] : '0;
      total++; if (in_ready !== m_in_ready()) begin bad++; $display("FAIL rnd_ready cyc %0d got %0b want %0b", i, in_ready, m_in_ready()); end
      total++; if (out_valid !== m_out_valid()) begin bad++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", i, out_valid, m_out_valid()); end
      total++; if (occupancy !== 2'(mq.size())) begin bad++; $display("FAIL rnd_occ cyc %0d got %0d want %0d", i, occupancy, mq.size()); end
      total++; if (out_ctrl !== want_ctrl) begin bad++; $display("FAIL rnd_ctrl cyc %0d got %0h want %0h", i, out_ctrl, want_ctrl); end
      if (mq.size() > 0) begin
        total++; if (out_data !== mq[0][DW+CW-1:CW]) begin bad++; $display("FAIL rnd_data cyc %0d got %0h want %0h", i, out_data, mq[0][DW+CW-1:CW]); end
      end
      total++; if (stall_cnt !== exp_stall() || flush_cnt !== exp_flush()) begin bad++; $display("FAIL rnd_cnt cyc %0d got %0d/%0d want %0d/%0d", i, stall_cnt, flush_cnt, exp_stall(), exp_flush()); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_flush();
    test_hold();
    test_stall_sat();
    test_reset_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
